// File: rtl/axisprng_pkg.sv
// Shared types and constants for the axisprng stream source.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package axisprng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_LFSR    = 1'b0;
    localparam logic MODE_COUNTER = 1'b1;

    // Tap mask for x^31 + x^13 + 1; callers truncate to their LGPOLY.
    function automatic logic [63:0] default_poly();
        return 64'h0000_0000_0000_2001;
    endfunction

    // Single one in the MSB: the LFSR fill used after reset and for a zero seed.
    function automatic logic [63:0] initial_fill(input int lgpoly);
        return 64'd1 << (lgpoly - 1);
    endfunction

endpackage

// File: rtl/axisprng_lfsr_multistep.sv
// Advances a Fibonacci LFSR by NSTEPS steps and collects the serial output bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register o_state.
// Ports: i_state current state; o_state state after NSTEPS steps;
//        o_word bit k = s[0] before step k.
module lfsr_multistep
    import axisprng_pkg::*;
#(
    parameter int                LGPOLY = 31,
    parameter logic [LGPOLY-1:0] POLY   = LGPOLY'(default_poly()),
    parameter int                NSTEPS = 32
) (
    input  logic [LGPOLY-1:0] i_state,
    output logic [LGPOLY-1:0] o_state,
    output logic [NSTEPS-1:0] o_word
);

    logic [LGPOLY-1:0] s;

    always_comb begin
        s      = i_state;
        o_word = '0;
        for (int k = 0; k < NSTEPS; k++) begin
            o_word[k] = s[0];
            s         = {^(s & POLY), s[LGPOLY-1:1]};
        end
        o_state = s;
    end

endmodule

// File: rtl/axisprng.sv
// AXI-stream LFSR / counter pattern source with seed load and TLAST framing.
// Latency: first beat valid the cycle after i_enable is seen in IDLE; 1 beat/clock after that.
// Backpressure: TVALID && !TREADY holds TDATA, TLAST, state and all counters.
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; i_enable start/stop;
//        i_mode 0=LFSR 1=counter; i_pktlen packet length-1; i_seed_valid/i_seed/o_seed_ready
//        seed load (IDLE only); o_busy in RUN/DRAIN; M_AXIS_* master stream.
module axisprng
    import axisprng_pkg::*;
#(
    parameter int                C_AXIS_DATA_WIDTH = 32,
    parameter int                LGPOLY            = 31,
    parameter logic [LGPOLY-1:0] POLY              = LGPOLY'(default_poly()),
    parameter int                LGPKT             = 8
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         i_enable,
    input  logic                         i_mode,
    input  logic [LGPKT-1:0]             i_pktlen,
    input  logic                         i_seed_valid,
    input  logic [LGPOLY-1:0]            i_seed,
    output logic                         o_seed_ready,
    output logic                         o_busy,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TLAST
);

    localparam int                W    = C_AXIS_DATA_WIDTH;
    localparam logic [LGPOLY-1:0] FILL = LGPOLY'(initial_fill(LGPOLY));

    state_t            state, state_nxt;
    logic [LGPOLY-1:0] lfsr_s, lfsr_src, lfsr_nxt;
    logic [W-1:0]      cnt, cnt_src, lfsr_word, gen_word, tdata;
    logic [LGPKT-1:0]  beat_cnt, pktlen_r;
    logic              mode_r, mode_sel, tvalid, tlast;
    logic              seed_load, accept, start, advance, finish;

    assign o_seed_ready  = (state == IDLE);
    assign o_busy        = (state != IDLE);
    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tdata;
    assign M_AXIS_TLAST  = tlast;

    assign seed_load = i_seed_valid && o_seed_ready;
    assign accept    = tvalid && M_AXIS_TREADY;

    // The registers hold the generator state *after* the word on TDATA, so the
    // next word is always computed from them. A seed arriving with i_enable is
    // muxed in ahead of the generator so it shapes the very first word.
    assign lfsr_src = seed_load ? ((i_seed == '0) ? FILL : i_seed) : lfsr_s;
    assign cnt_src  = seed_load ? W'(i_seed) : cnt;
    assign mode_sel = (state == IDLE) ? i_mode : mode_r;
    assign gen_word = (mode_sel == MODE_COUNTER) ? cnt_src : lfsr_word;

    lfsr_multistep #(
        .LGPOLY (LGPOLY),
        .POLY   (POLY),
        .NSTEPS (W)
    ) u_step (
        .i_state (lfsr_src),
        .o_state (lfsr_nxt),
        .o_word  (lfsr_word)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    // start: load first word; advance: load next word after an accepted beat;
    // finish: last TLAST beat accepted with i_enable low, stop streaming.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (accept && tlast && !i_enable) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = i_enable ? RUN : DRAIN;
                    advance   = accept;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
            tdata    <= '0;
            lfsr_s   <= FILL;
            cnt      <= '0;
            beat_cnt <= '0;
            pktlen_r <= '0;
            mode_r   <= MODE_LFSR;
        end else begin
            // Only the generator feeding the stream advances; the other keeps
            // its value (or takes the seed) so each mode resumes where it left off.
            if (start || advance) begin
                tvalid <= 1'b1;
                tdata  <= gen_word;
                lfsr_s <= (mode_sel == MODE_LFSR) ? lfsr_nxt : lfsr_src;
                cnt    <= (mode_sel == MODE_COUNTER) ? cnt_src + W'(1) : cnt_src;
            end else if (seed_load) begin
                lfsr_s <= lfsr_src;
                cnt    <= cnt_src;
            end

            if (start)
                mode_r <= i_mode;

            if (start || (advance && tlast)) begin
                beat_cnt <= '0;
                pktlen_r <= i_pktlen;
                tlast    <= (i_pktlen == '0);
            end else if (advance) begin
                beat_cnt <= beat_cnt + LGPKT'(1);
                tlast    <= ((beat_cnt + LGPKT'(1)) == pktlen_r);
            end

            if (finish) begin
                tvalid   <= 1'b0;
                tlast    <= 1'b0;
                beat_cnt <= '0;
            end
        end
    end

endmodule
